// File: rtl/norm_shift_pipe.sv
// Pipelined leading-one normaliser: one binary shift stage per register,
// exponent adjusted by the total shift in the last stage.
module norm_shift_pipe #(
    parameter int WIDTH = 24,
    parameter int SHW   = 5,
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mant,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [SHW-1:0]   out_shamt,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_zero,
    output logic             out_uflow
);

    logic                         w_adv;

    logic [SHW-1:0][WIDTH-1:0]    r_mant;
    logic [SHW-1:0][SHW-1:0]      r_sh;
    logic [SHW-1:0][EXP_W-1:0]    r_exp;
    logic [SHW-1:0]               r_vld;
    logic                         r_zero;
    logic                         r_uflow;

    logic [SHW-1:0][WIDTH-1:0]    w_mant_i;
    logic [SHW-1:0][WIDTH-1:0]    w_mant_n;
    logic [SHW-1:0][SHW-1:0]      w_sh_i;
    logic [SHW-1:0][SHW-1:0]      w_sh_n;
    logic [SHW-1:0][EXP_W-1:0]    w_exp_i;
    logic [SHW-1:0][EXP_W-1:0]    w_exp_n;
    logic [SHW-1:0]               w_vld_i;
    logic [SHW-1:0]               w_hit;

    logic [EXP_W:0]               w_diff;
    logic                         w_zero_n;

    // A single global stall: the whole pipe freezes while the output waits.
    assign w_adv    = ~(out_valid & ~out_ready);
    assign in_ready = w_adv;

    for (genvar j = 0; j < SHW; j++) begin : g_stage
        localparam int K = SHW - 1 - j;
        localparam int S = 1 << K;

        if (j == 0) begin : g_src_in
            assign w_mant_i[j] = in_mant;
            assign w_sh_i[j]   = '0;
            assign w_exp_i[j]  = in_exp;
            assign w_vld_i[j]  = in_valid & in_ready;
        end else begin : g_src_reg
            assign w_mant_i[j] = r_mant[j-1];
            assign w_sh_i[j]   = r_sh[j-1];
            assign w_exp_i[j]  = r_exp[j-1];
            assign w_vld_i[j]  = r_vld[j-1];
        end

        if (S >= WIDTH) begin : g_wide
            assign w_hit[j]    = ~|w_mant_i[j];
            assign w_mant_n[j] = w_hit[j] ? '0 : w_mant_i[j];
        end else begin : g_part
            assign w_hit[j]    = ~|w_mant_i[j][WIDTH-1 -: S];
            assign w_mant_n[j] = w_hit[j] ? (w_mant_i[j] << S)
                                          : w_mant_i[j];
        end

        assign w_sh_n[j] = w_sh_i[j] | (SHW'(w_hit[j]) << K);

        if (j == SHW - 1) begin : g_last
            assign w_exp_n[j] = w_diff[EXP_W-1:0];
        end else begin : g_pass
            assign w_exp_n[j] = w_exp_i[j];
        end
    end

    // Borrow out of the widened subtraction is the underflow flag.
    assign w_diff   = {1'b0, w_exp_i[SHW-1]}
                    - (EXP_W+1)'(w_sh_n[SHW-1]);
    assign w_zero_n = ~|w_mant_n[SHW-1];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_vld   <= '0;
            r_mant  <= '0;
            r_sh    <= '0;
            r_exp   <= '0;
            r_zero  <= 1'b0;
            r_uflow <= 1'b0;
        end else begin
            if (w_adv) begin
                r_vld   <= w_vld_i;
                r_mant  <= w_mant_n;
                r_sh    <= w_sh_n;
                r_exp   <= w_exp_n;
                r_zero  <= w_zero_n;
                r_uflow <= w_diff[EXP_W];
            end
            if (flush) begin
                r_vld <= '0;
            end
        end
    end

    assign out_valid = r_vld[SHW-1];
    assign out_mant  = r_mant[SHW-1];
    assign out_shamt = r_sh[SHW-1];
    assign out_exp   = r_exp[SHW-1];
    assign out_zero  = r_zero;
    assign out_uflow = r_uflow;

endmodule
